// File: rtl/cpu_controller_if.sv
// Control/datapath bundle between the multicycle controller and the 16-bit datapath.
interface cpu_controller_if;
  logic [15:0] instr;
  logic        mem_ready;
  logic        cond_true;
  logic [3:0]  opcode;
  logic [3:0]  opext;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        wb_sel;
  logic [1:0]  alu_src_b;
  logic        flags_write;
  logic        illegal;

  modport master (
    input  instr, mem_ready, cond_true,
    output opcode, opext, ir_write, pc_write, pc_src, mem_read, mem_write,
           reg_write, wb_sel, alu_src_b, flags_write, illegal
  );

  modport slave (
    output instr, mem_ready, cond_true,
    input  opcode, opext, ir_write, pc_write, pc_src, mem_read, mem_write,
           reg_write, wb_sel, alu_src_b, flags_write, illegal
  );
endinterface

// File: rtl/cpu_controller.sv
// Multicycle fetch/decode/execute/memory/writeback controller for the 16-bit datapath.
// Holds opcode/opext for the ALU-control decoder and issues all datapath strobes.
module cpu_controller #(
  parameter int unsigned WAIT_MAX = 15
) (
  input logic             clk,
  input logic             reset,
  cpu_controller_if.master bus
);

  localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
  logic [3:0]       opcode_q, opext_q;
  logic             timeout_c;
  logic             unused_c;

  assign unused_c   = ^{bus.instr[11:8], bus.instr[3:0]};
  assign bus.opcode = opcode_q;
  assign bus.opext  = opext_q;
  assign timeout_c  = (WAIT_MAX != 0) && (32'(wait_cnt) >= WAIT_MAX);

  // State, wait counter and held instruction fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      opcode_q <= 4'b0000;
      opext_q  <= 4'b0000;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (bus.ir_write) begin
        opcode_q <= bus.instr[15:12];
        opext_q  <= bus.instr[7:4];
      end
    end
  end

  // Next state and strobes; everything stays low while reset is high
  always_comb begin
    state_nx        = state;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.reg_write   = 1'b0;
    bus.wb_sel      = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.flags_write = 1'b0;
    bus.illegal     = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          if (timeout_c) begin
            bus.illegal = 1'b1;
          end else begin
            bus.mem_read = 1'b1;
            if (bus.mem_ready) begin
              bus.ir_write = 1'b1;
              bus.pc_write = 1'b1;
              state_nx     = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          if (opcode_q == 4'b0000 &&
              opext_q inside {4'b0101, 4'b1001, 4'b0001, 4'b0011, 4'b0010, 4'b1011})
            state_nx = S_EXEC_R;
          else if (opcode_q inside {4'b0101, 4'b1001, 4'b0001, 4'b0011, 4'b0010, 4'b1011})
            state_nx = S_EXEC_I;
          else if (opcode_q == 4'b0100 && opext_q == 4'b0000)
            state_nx = S_MEMRD;
          else if (opcode_q == 4'b0100 && opext_q == 4'b0100)
            state_nx = S_MEMWR;
          else if (opcode_q == 4'b1100)
            state_nx = S_BRANCH;
          else begin
            bus.illegal = 1'b1;
            state_nx    = S_FETCH;
          end
        end
        S_EXEC_R: begin
          bus.flags_write = 1'b1;
          bus.reg_write   = (opext_q != 4'b1011);
          state_nx        = S_FETCH;
        end
        S_EXEC_I: begin
          // Logical immediates are zero-extended, arithmetic ones sign-extended
          bus.alu_src_b   = (opcode_q inside {4'b0001, 4'b0010, 4'b0011}) ? 2'b10 : 2'b01;
          bus.flags_write = 1'b1;
          bus.reg_write   = (opcode_q != 4'b1011);
          state_nx        = S_FETCH;
        end
        S_MEMRD: begin
          if (timeout_c) begin
            bus.illegal = 1'b1;
            state_nx    = S_FETCH;
          end else begin
            bus.mem_read = 1'b1;
            if (bus.mem_ready) state_nx = S_MEMWB;
          end
        end
        S_MEMWB: begin
          bus.reg_write = 1'b1;
          bus.wb_sel    = 1'b1;
          state_nx      = S_FETCH;
        end
        S_MEMWR: begin
          if (timeout_c) begin
            bus.illegal = 1'b1;
            state_nx    = S_FETCH;
          end else begin
            bus.mem_write = 1'b1;
            if (bus.mem_ready) state_nx = S_FETCH;
          end
        end
        S_BRANCH: begin
          bus.pc_write = bus.cond_true;
          bus.pc_src   = bus.cond_true;
          state_nx     = S_FETCH;
        end
        default: state_nx = S_FETCH;
      endcase
    end
  end

  // Wait counter restarts on every state entry (incl. timeout re-entry of FETCH)
  always_comb begin
    wait_cnt_nx = wait_cnt;
    if (state_nx != state || timeout_c)
      wait_cnt_nx = '0;
    else if ((WAIT_MAX != 0) && !bus.mem_ready &&
             (state == S_FETCH || state == S_MEMRD || state == S_MEMWR))
      wait_cnt_nx = wait_cnt + CNT_W'(1);
  end

endmodule
